// File: rtl/priv_trap_pkg.sv
// -----------------------------------------------------------------------------
// priv_trap_pkg
// Shared types and constants for the machine-mode trap sequencer.
//   trap_state_t      : sequencer FSM states
//   ex_code_t         : exception mcause codes (MSB of mcause is 0)
//   int_code_t        : interrupt mcause codes (MSB of mcause is 1)
//   MTVEC_VECTORED    : mtvec.MODE value that selects vectored interrupts
//   code_uses_badaddr : whether an exception code reports badaddr in mtval
// -----------------------------------------------------------------------------
package priv_trap_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CSR_WR   = 2'd1,
    REDIRECT = 2'd2,
    RET      = 2'd3
  } trap_state_t;

  typedef logic [30:0] ex_code_t;
  typedef logic [30:0] int_code_t;

  localparam ex_code_t EX_MAL_INSN   = 31'd0;
  localparam ex_code_t EX_FAULT_INSN = 31'd1;
  localparam ex_code_t EX_ILLEGAL    = 31'd2;
  localparam ex_code_t EX_BREAKPOINT = 31'd3;
  localparam ex_code_t EX_MAL_L      = 31'd4;
  localparam ex_code_t EX_FAULT_L    = 31'd5;
  localparam ex_code_t EX_MAL_S      = 31'd6;
  localparam ex_code_t EX_FAULT_S    = 31'd7;
  localparam ex_code_t EX_ENV_M      = 31'd11;

  localparam int_code_t INT_SOFT  = 31'd3;
  localparam int_code_t INT_TIMER = 31'd7;
  localparam int_code_t INT_EXT   = 31'd11;

  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  // Address-related exceptions (codes 0..7 except illegal instruction)
  // report the faulting address; everything else writes mtval = 0.
  function automatic logic code_uses_badaddr(input ex_code_t code);
    return (code <= EX_FAULT_S) && (code != EX_ILLEGAL);
  endfunction

endpackage

// File: rtl/priv_trap_prio.sv
// -----------------------------------------------------------------------------
// priv_trap_prio
// Purely combinational trap priority encoder. Exceptions always beat
// interrupts; within each group the fixed priority order below applies.
// Inputs : exception flags, RISC-MGMT exception + extension index,
//          raw interrupt lines, global and per-source interrupt enables.
// Outputs: take        - some exception or enabled interrupt is present
//          is_int      - the winner is an interrupt
//          cause       - mcause code of the winner (without MSB)
//          use_badaddr - mtval should capture badaddr for this winner
// -----------------------------------------------------------------------------
module priv_trap_prio
  import priv_trap_pkg::*;
#(
  parameter int RMGMT_CAUSE_W    = 2,
  parameter int RMGMT_CAUSE_BASE = 24
) (
  input  logic                     fault_insn,
  input  logic                     mal_insn,
  input  logic                     illegal_insn,
  input  logic                     fault_l,
  input  logic                     mal_l,
  input  logic                     fault_s,
  input  logic                     mal_s,
  input  logic                     breakpoint,
  input  logic                     env_m,
  input  logic                     ex_rmgmt,
  input  logic [RMGMT_CAUSE_W-1:0] ex_rmgmt_cause,
  input  logic                     timer_int,
  input  logic                     soft_int,
  input  logic                     ext_int,
  input  logic                     mstatus_mie,
  input  logic                     mie_mtie,
  input  logic                     mie_msie,
  input  logic                     mie_meie,
  output logic                     take,
  output logic                     is_int,
  output logic [30:0]              cause,
  output logic                     use_badaddr
);

  localparam ex_code_t RMGMT_BASE = ex_code_t'(RMGMT_CAUSE_BASE);

  logic any_ex;
  logic ext_take;
  logic soft_take;
  logic timer_take;
  logic int_take;

  assign any_ex = fault_insn | mal_insn | illegal_insn | fault_l | mal_l |
                  fault_s | mal_s | breakpoint | env_m | ex_rmgmt;

  assign ext_take   = ext_int & mie_meie;
  assign soft_take  = soft_int & mie_msie;
  assign timer_take = timer_int & mie_mtie;
  assign int_take   = mstatus_mie & (ext_take | soft_take | timer_take);

  // NOTE: every output of a combinational block gets a default before the
  // if/case chain, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cause  = '0;
    is_int = 1'b0;
    if      (fault_insn)   cause = EX_FAULT_INSN;
    else if (mal_insn)     cause = EX_MAL_INSN;
    else if (illegal_insn) cause = EX_ILLEGAL;
    else if (breakpoint)   cause = EX_BREAKPOINT;
    else if (env_m)        cause = EX_ENV_M;
    else if (mal_s)        cause = EX_MAL_S;
    else if (mal_l)        cause = EX_MAL_L;
    else if (fault_s)      cause = EX_FAULT_S;
    else if (fault_l)      cause = EX_FAULT_L;
    else if (ex_rmgmt)     cause = RMGMT_BASE + 31'(ex_rmgmt_cause);
    else if (int_take) begin
      is_int = 1'b1;
      if      (ext_take)  cause = INT_EXT;
      else if (soft_take) cause = INT_SOFT;
      else                cause = INT_TIMER;
    end
  end

  assign take        = any_ex | int_take;
  assign use_badaddr = any_ex & code_uses_badaddr(cause);

endmodule

// File: rtl/priv_trap_sequencer.sv
// -----------------------------------------------------------------------------
// priv_trap_sequencer
// Sequences machine-mode trap entry and mret as a registered two-step commit:
//   trap: IDLE -> CSR_WR (mepc/mcause/mtval/mstatus strobes) -> REDIRECT
//         (insert_pc to the trap vector) -> IDLE
//   mret: IDLE -> RET (insert_pc to mepc, mstatus_ret) -> IDLE
// Decisions are made only in IDLE while pipe_clear is high; cause, interrupt
// flag, epc and tval are captured on that edge so later input changes are
// ignored. All outputs decode from the registered state and are glitch-free.
// Ports:
//   CLK, nRST                 clock, synchronous active-low reset
//   exception flags, ex_rmgmt/ex_rmgmt_cause, ret, pipe_clear, epc, badaddr
//   timer/soft/ext_int, mstatus_mie, mie_*   interrupt sources and enables
//   mtvec, mepc_r             CSR values used for the redirect target
//   m*_wen / m*_wdata         CSR write strobes and data (CSR_WR only)
//   mstatus_trap/_ret         mstatus stack push / pop pulses
//   insert_pc, priv_pc, intr  fetch redirect and interrupt indication
//   busy                      sequencer is not IDLE
// -----------------------------------------------------------------------------
module priv_trap_sequencer
  import priv_trap_pkg::*;
#(
  parameter int RMGMT_CAUSE_W    = 2,
  parameter int RMGMT_CAUSE_BASE = 24
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     fault_insn,
  input  logic                     mal_insn,
  input  logic                     illegal_insn,
  input  logic                     fault_l,
  input  logic                     mal_l,
  input  logic                     fault_s,
  input  logic                     mal_s,
  input  logic                     breakpoint,
  input  logic                     env_m,
  input  logic                     ex_rmgmt,
  input  logic [RMGMT_CAUSE_W-1:0] ex_rmgmt_cause,
  input  logic                     ret,
  input  logic                     pipe_clear,
  input  logic [31:0]              epc,
  input  logic [31:0]              badaddr,
  input  logic                     timer_int,
  input  logic                     soft_int,
  input  logic                     ext_int,
  input  logic                     mstatus_mie,
  input  logic                     mie_mtie,
  input  logic                     mie_msie,
  input  logic                     mie_meie,
  input  logic [31:0]              mtvec,
  input  logic [31:0]              mepc_r,
  output logic                     mepc_wen,
  output logic                     mcause_wen,
  output logic                     mtval_wen,
  output logic [31:0]              mepc_wdata,
  output logic [31:0]              mcause_wdata,
  output logic [31:0]              mtval_wdata,
  output logic                     mstatus_trap,
  output logic                     mstatus_ret,
  output logic                     insert_pc,
  output logic [31:0]              priv_pc,
  output logic                     intr,
  output logic                     busy
);

  trap_state_t state_q, state_d;
  logic [30:0] cause_q, cause_d;
  logic        intr_q, intr_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tval_q, tval_d;

  logic        pr_take;
  logic        pr_is_int;
  logic [30:0] pr_cause;
  logic        pr_use_badaddr;

  logic [31:0] vec_base;
  logic [31:0] vec_offset;

  priv_trap_prio #(
    .RMGMT_CAUSE_W    (RMGMT_CAUSE_W),
    .RMGMT_CAUSE_BASE (RMGMT_CAUSE_BASE)
  ) u_prio (
    .fault_insn     (fault_insn),
    .mal_insn       (mal_insn),
    .illegal_insn   (illegal_insn),
    .fault_l        (fault_l),
    .mal_l          (mal_l),
    .fault_s        (fault_s),
    .mal_s          (mal_s),
    .breakpoint     (breakpoint),
    .env_m          (env_m),
    .ex_rmgmt       (ex_rmgmt),
    .ex_rmgmt_cause (ex_rmgmt_cause),
    .timer_int      (timer_int),
    .soft_int       (soft_int),
    .ext_int        (ext_int),
    .mstatus_mie    (mstatus_mie),
    .mie_mtie       (mie_mtie),
    .mie_msie       (mie_msie),
    .mie_meie       (mie_meie),
    .take           (pr_take),
    .is_int         (pr_is_int),
    .cause          (pr_cause),
    .use_badaddr    (pr_use_badaddr)
  );

  // Next-state and capture logic. A pending trap (exception or enabled
  // interrupt) outranks a committing mret.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    intr_d  = intr_q;
    epc_d   = epc_q;
    tval_d  = tval_q;
    unique case (state_q)
      IDLE: begin
        if (pipe_clear) begin
          if (pr_take) begin
            state_d = CSR_WR;
            cause_d = pr_cause;
            intr_d  = pr_is_int;
            epc_d   = epc & ~32'h3;
            tval_d  = pr_use_badaddr ? badaddr : 32'h0;
          end else if (ret) begin
            state_d = RET;
          end
        end
      end
      CSR_WR:   state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      RET:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Vectored mode only offsets interrupts; exceptions always go to the base.
  assign vec_base   = {mtvec[31:2], 2'b00};
  assign vec_offset = ((mtvec[1:0] == MTVEC_VECTORED) && intr_q) ?
                      {cause_q[29:0], 2'b00} : 32'h0;

  always_comb begin
    mepc_wen     = 1'b0;
    mcause_wen   = 1'b0;
    mtval_wen    = 1'b0;
    mepc_wdata   = 32'h0;
    mcause_wdata = 32'h0;
    mtval_wdata  = 32'h0;
    mstatus_trap = 1'b0;
    mstatus_ret  = 1'b0;
    insert_pc    = 1'b0;
    priv_pc      = 32'h0;
    intr         = 1'b0;
    unique case (state_q)
      CSR_WR: begin
        mepc_wen     = 1'b1;
        mcause_wen   = 1'b1;
        mtval_wen    = 1'b1;
        mstatus_trap = 1'b1;
        mepc_wdata   = epc_q;
        mcause_wdata = {intr_q, cause_q};
        mtval_wdata  = tval_q;
      end
      REDIRECT: begin
        insert_pc = 1'b1;
        intr      = intr_q;
        priv_pc   = vec_base + vec_offset;
      end
      RET: begin
        insert_pc   = 1'b1;
        mstatus_ret = 1'b1;
        priv_pc     = mepc_r;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      // NOTE: the captured trap fields are reset along with the state so a
      // reset mid-sequence leaves no stale cause/epc/tval behind.
      cause_q <= '0;
      intr_q  <= 1'b0;
      epc_q   <= 32'h0;
      tval_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      intr_q  <= intr_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
    end
  end

endmodule

// File: tb/tb_priv_trap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_priv_trap_sequencer
// Directed scenarios plus randomized traffic against a table-driven model of
// trap selection, CSR data and redirect targets.
// -----------------------------------------------------------------------------
module tb_priv_trap_sequencer;

  localparam int RMGMT_CAUSE_W    = 2;
  localparam int RMGMT_CAUSE_BASE = 24;

  // {mepc_wen, mcause_wen, mtval_wen, mstatus_trap, mstatus_ret, insert_pc, intr, busy}
  localparam logic [7:0] S_IDLE      = 8'b0000_0000;
  localparam logic [7:0] S_CSR       = 8'b1111_0001;
  localparam logic [7:0] S_REDIR     = 8'b0000_0101;
  localparam logic [7:0] S_REDIR_INT = 8'b0000_0111;
  localparam logic [7:0] S_RET       = 8'b0000_1101;

  logic CLK, nRST;
  logic fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s;
  logic breakpoint, env_m, ex_rmgmt, ret, pipe_clear;
  logic [RMGMT_CAUSE_W-1:0] ex_rmgmt_cause;
  logic [31:0] epc, badaddr, mtvec, mepc_r;
  logic timer_int, soft_int, ext_int, mstatus_mie, mie_mtie, mie_msie, mie_meie;
  logic mepc_wen, mcause_wen, mtval_wen, mstatus_trap, mstatus_ret;
  logic insert_pc, intr, busy;
  logic [31:0] mepc_wdata, mcause_wdata, mtval_wdata, priv_pc;
  logic [7:0] strb;

  int errors = 0;
  int checks = 0;

  assign strb = {mepc_wen, mcause_wen, mtval_wen, mstatus_trap,
                 mstatus_ret, insert_pc, intr, busy};

  priv_trap_sequencer #(
    .RMGMT_CAUSE_W    (RMGMT_CAUSE_W),
    .RMGMT_CAUSE_BASE (RMGMT_CAUSE_BASE)
  ) dut (
    .CLK (CLK), .nRST (nRST),
    .fault_insn (fault_insn), .mal_insn (mal_insn), .illegal_insn (illegal_insn),
    .fault_l (fault_l), .mal_l (mal_l), .fault_s (fault_s), .mal_s (mal_s),
    .breakpoint (breakpoint), .env_m (env_m),
    .ex_rmgmt (ex_rmgmt), .ex_rmgmt_cause (ex_rmgmt_cause),
    .ret (ret), .pipe_clear (pipe_clear), .epc (epc), .badaddr (badaddr),
    .timer_int (timer_int), .soft_int (soft_int), .ext_int (ext_int),
    .mstatus_mie (mstatus_mie), .mie_mtie (mie_mtie), .mie_msie (mie_msie),
    .mie_meie (mie_meie), .mtvec (mtvec), .mepc_r (mepc_r),
    .mepc_wen (mepc_wen), .mcause_wen (mcause_wen), .mtval_wen (mtval_wen),
    .mepc_wdata (mepc_wdata), .mcause_wdata (mcause_wdata), .mtval_wdata (mtval_wdata),
    .mstatus_trap (mstatus_trap), .mstatus_ret (mstatus_ret),
    .insert_pc (insert_pc), .priv_pc (priv_pc), .intr (intr), .busy (busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Inputs change just after the falling edge; outputs are sampled there too.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic clear_events();
    {fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s} = '0;
    {breakpoint, env_m, ex_rmgmt, ret, pipe_clear} = '0;
    ex_rmgmt_cause = '0;
    {timer_int, soft_int, ext_int, mstatus_mie, mie_mtie, mie_msie, mie_meie} = '0;
    epc     = 32'h0;
    badaddr = 32'h0;
  endtask

  task automatic drive_random(input bit keep_csrs);
    fault_insn   = ($urandom_range(0, 9) == 0);
    mal_insn     = ($urandom_range(0, 9) == 0);
    illegal_insn = ($urandom_range(0, 9) == 0);
    fault_l      = ($urandom_range(0, 9) == 0);
    mal_l        = ($urandom_range(0, 9) == 0);
    fault_s      = ($urandom_range(0, 9) == 0);
    mal_s        = ($urandom_range(0, 9) == 0);
    breakpoint   = ($urandom_range(0, 9) == 0);
    env_m        = ($urandom_range(0, 9) == 0);
    ex_rmgmt     = ($urandom_range(0, 9) == 0);
    ex_rmgmt_cause = RMGMT_CAUSE_W'($urandom);
    timer_int    = $urandom_range(0, 1) != 0;
    soft_int     = $urandom_range(0, 1) != 0;
    ext_int      = $urandom_range(0, 1) != 0;
    mstatus_mie  = $urandom_range(0, 1) != 0;
    mie_mtie     = $urandom_range(0, 3) != 0;
    mie_msie     = $urandom_range(0, 3) != 0;
    mie_meie     = $urandom_range(0, 3) != 0;
    ret          = $urandom_range(0, 3) == 0;
    pipe_clear   = $urandom_range(0, 3) != 0;
    epc          = $urandom;
    badaddr      = $urandom;
    if (!keep_csrs) begin
      mtvec  = $urandom;
      mepc_r = $urandom;
    end
  endtask

  // Reference: pick the first raised exception from a priority table, else the
  // highest enabled interrupt; derive CSR data and the redirect target.
  task automatic model(output bit e_trap, output bit e_ret, output logic [31:0] e_cause,
                       output logic [31:0] e_tval, output logic [31:0] e_mepc,
                       output logic [31:0] e_pc, output bit e_intr);
    bit fl [10];
    int cd [10];
    int code;
    bit ex_hit;
    fl = '{fault_insn, mal_insn, illegal_insn, breakpoint, env_m,
           mal_s, mal_l, fault_s, fault_l, ex_rmgmt};
    cd = '{1, 0, 2, 3, 11, 6, 4, 7, 5, RMGMT_CAUSE_BASE + int'(ex_rmgmt_cause)};
    ex_hit = 1'b0;
    e_intr = 1'b0;
    code   = 0;
    for (int i = 0; i < 10; i++) begin
      if (fl[i] && !ex_hit) begin
        ex_hit = 1'b1;
        code   = cd[i];
      end
    end
    if (!ex_hit && mstatus_mie) begin
      if (ext_int && mie_meie)        begin e_intr = 1'b1; code = 11; end
      else if (soft_int && mie_msie)  begin e_intr = 1'b1; code = 3;  end
      else if (timer_int && mie_mtie) begin e_intr = 1'b1; code = 7;  end
    end
    e_trap  = pipe_clear && (ex_hit || e_intr);
    e_ret   = pipe_clear && ret && !(ex_hit || e_intr);
    e_cause = 32'(code) | (e_intr ? 32'h8000_0000 : 32'h0);
    e_tval  = (ex_hit && (code inside {0, 1, 3, 4, 5, 6, 7})) ? badaddr : 32'h0;
    e_mepc  = epc & ~32'h3;
    e_pc    = (mtvec & ~32'h3) +
              (((mtvec & 32'h3) == 32'h1 && e_intr) ? 32'(code * 4) : 32'h0);
  endtask

  task automatic test_reset();
    clear_events();
    mtvec = 32'h0; mepc_r = 32'h0;
    nRST = 1'b0;
    step(); step();
    checks++;
    if ({strb, mepc_wdata, mcause_wdata, mtval_wdata, priv_pc} !== {S_IDLE, 128'h0}) begin
      errors++;
      $display("FAIL reset_outputs: got strb=%b pc=%h want all zero", strb, priv_pc);
    end
    nRST = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_sequence();
    bit seen = 1'b0;
    clear_events();
    mtvec = 32'h0000_0100; mal_l = 1'b1; pipe_clear = 1'b1; badaddr = 32'h1234_5678;
    step();
    checks++;
    if (strb !== S_CSR) begin
      errors++; $display("FAIL midrst_csr: got %b want %b", strb, S_CSR);
    end
    nRST = 1'b0;
    clear_events();
    step();
    checks++;
    if ({strb, mtval_wdata} !== {S_IDLE, 32'h0}) begin
      errors++; $display("FAIL midrst_idle: got strb=%b mtval=%h want zeros", strb, mtval_wdata);
    end
    nRST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (insert_pc || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL midrst_no_redirect: got insert_pc/busy=1 want 0");
    end
  endtask

  task automatic test_illegal_fault_l();
    clear_events();
    mtvec = 32'h0000_0300; epc = 32'h0000_1006; badaddr = 32'hDEAD_BEEF;
    illegal_insn = 1'b1; fault_l = 1'b1; pipe_clear = 1'b1;
    step();
    checks++;
    if ({strb, mepc_wdata, mcause_wdata, mtval_wdata} !== {S_CSR, 32'h1004, 32'd2, 32'd0}) begin
      errors++;
      $display("FAIL illegal_csr: got strb=%b mepc=%h mcause=%h mtval=%h want %b 1004 2 0",
               strb, mepc_wdata, mcause_wdata, mtval_wdata, S_CSR);
    end
    clear_events();
    step();
    checks++;
    if ({strb, priv_pc} !== {S_REDIR, 32'h0000_0300}) begin
      errors++; $display("FAIL illegal_redirect: got strb=%b pc=%h want %b 300", strb, priv_pc, S_REDIR);
    end
    step();
  endtask

  task automatic test_mal_s();
    clear_events();
    mtvec = 32'h0000_0100; badaddr = 32'h8000_0003; epc = 32'h0000_2000;
    mal_s = 1'b1; pipe_clear = 1'b1;
    step();
    checks++;
    if ({strb, mcause_wdata, mtval_wdata} !== {S_CSR, 32'd6, 32'h8000_0003}) begin
      errors++;
      $display("FAIL mal_s_csr: got strb=%b mcause=%h mtval=%h want 6 80000003", strb, mcause_wdata, mtval_wdata);
    end
    clear_events();
    step();
    checks++;
    if ({strb, priv_pc} !== {S_REDIR, 32'h0000_0100}) begin
      errors++; $display("FAIL mal_s_redirect: got strb=%b pc=%h want %b 100", strb, priv_pc, S_REDIR);
    end
    step();
  endtask

  task automatic test_interrupt();
    clear_events();
    mtvec = 32'h0000_0201; epc = 32'h0000_3008; badaddr = 32'hFFFF_FFFF;
    timer_int = 1'b1; ext_int = 1'b1; mstatus_mie = 1'b1;
    mie_mtie = 1'b1; mie_msie = 1'b1; mie_meie = 1'b1; pipe_clear = 1'b1;
    step();
    checks++;
    if ({strb, mepc_wdata, mcause_wdata, mtval_wdata} !== {S_CSR, 32'h3008, 32'h8000_000B, 32'h0}) begin
      errors++;
      $display("FAIL int_csr: got strb=%b mepc=%h mcause=%h mtval=%h want 3008 8000000b 0",
               strb, mepc_wdata, mcause_wdata, mtval_wdata);
    end
    clear_events();
    step();
    checks++;
    if ({strb, priv_pc} !== {S_REDIR_INT, 32'h0000_022C}) begin
      errors++; $display("FAIL int_redirect: got strb=%b pc=%h want %b 22c", strb, priv_pc, S_REDIR_INT);
    end
    step();
  endtask

  task automatic test_int_masked();
    clear_events();
    mtvec = 32'h0000_0201;
    timer_int = 1'b1; ext_int = 1'b1; mstatus_mie = 1'b0;
    mie_mtie = 1'b1; mie_msie = 1'b1; mie_meie = 1'b1; pipe_clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (strb !== S_IDLE) begin
        errors++; $display("FAIL int_masked_c%0d: got strb=%b want %b", i, strb, S_IDLE);
      end
    end
    clear_events();
  endtask

  task automatic test_ret();
    clear_events();
    mepc_r = 32'h0000_4000; ret = 1'b1; pipe_clear = 1'b1;
    step();
    checks++;
    if ({strb, priv_pc} !== {S_RET, 32'h0000_4000}) begin
      errors++; $display("FAIL ret_redirect: got strb=%b pc=%h want %b 4000", strb, priv_pc, S_RET);
    end
    clear_events();
    step();
    checks++;
    if (strb !== S_IDLE) begin
      errors++; $display("FAIL ret_done: got strb=%b want %b", strb, S_IDLE);
    end
  endtask

  task automatic test_ret_env_m();
    clear_events();
    mtvec = 32'h0000_0100; mepc_r = 32'h0000_4000; epc = 32'h0000_5000;
    ret = 1'b1; env_m = 1'b1; pipe_clear = 1'b1;
    step();
    checks++;
    if ({strb, mcause_wdata} !== {S_CSR, 32'd11}) begin
      errors++; $display("FAIL ret_env_csr: got strb=%b mcause=%h want %b b", strb, mcause_wdata, S_CSR);
    end
    clear_events();
    step();
    checks++;
    if ({strb, priv_pc} !== {S_REDIR, 32'h0000_0100}) begin
      errors++; $display("FAIL ret_env_redirect: got strb=%b pc=%h want %b 100", strb, priv_pc, S_REDIR);
    end
    step();
  endtask

  task automatic test_rmgmt();
    clear_events();
    mtvec = 32'h0000_0100; badaddr = 32'hCAFE_0000;
    ex_rmgmt = 1'b1; ex_rmgmt_cause = 2'd2; pipe_clear = 1'b1;
    step();
    checks++;
    if ({strb, mcause_wdata, mtval_wdata} !== {S_CSR, 32'd26, 32'h0}) begin
      errors++;
      $display("FAIL rmgmt_csr: got strb=%b mcause=%h mtval=%h want 1a 0", strb, mcause_wdata, mtval_wdata);
    end
    clear_events();
    step(); step();
  endtask

  task automatic test_pipe_clear_hold();
    clear_events();
    mtvec = 32'h0000_0100; env_m = 1'b1; pipe_clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (strb !== S_IDLE) begin
        errors++; $display("FAIL hold_c%0d: got strb=%b want %b", i, strb, S_IDLE);
      end
    end
    pipe_clear = 1'b1;
    step();
    checks++;
    if ({strb, mcause_wdata} !== {S_CSR, 32'd11}) begin
      errors++; $display("FAIL hold_release: got strb=%b mcause=%h want %b b", strb, mcause_wdata, S_CSR);
    end
    clear_events();
    step(); step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [4];
    want = '{S_CSR, S_REDIR, S_IDLE, S_CSR};
    clear_events();
    mtvec = 32'h0000_0100; breakpoint = 1'b1; pipe_clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (strb !== want[i]) begin
        errors++; $display("FAIL b2b_c%0d: got strb=%b want %b", i, strb, want[i]);
      end
    end
    clear_events();
    step(); step();
  endtask

  task automatic test_random();
    bit e_trap, e_ret, e_intr;
    logic [31:0] e_cause, e_tval, e_mepc, e_pc, e_ret_pc;
    logic [7:0] e_redir;
    for (int it = 0; it < 400; it++) begin
      drive_random(1'b0);
      model(e_trap, e_ret, e_cause, e_tval, e_mepc, e_pc, e_intr);
      e_ret_pc = mepc_r;
      step();
      if (e_trap) begin
        checks++;
        if ({strb, mepc_wdata, mcause_wdata, mtval_wdata} !== {S_CSR, e_mepc, e_cause, e_tval}) begin
          errors++;
          $display("FAIL rand%0d_csr: got strb=%b mepc=%h mcause=%h mtval=%h want %b %h %h %h",
                   it, strb, mepc_wdata, mcause_wdata, mtval_wdata, S_CSR, e_mepc, e_cause, e_tval);
        end
        drive_random(1'b1);
        step();
        e_redir = e_intr ? S_REDIR_INT : S_REDIR;
        checks++;
        if ({strb, priv_pc} !== {e_redir, e_pc}) begin
          errors++;
          $display("FAIL rand%0d_redirect: got strb=%b pc=%h want %b %h", it, strb, priv_pc, e_redir, e_pc);
        end
        drive_random(1'b1);
        step();
      end else if (e_ret) begin
        checks++;
        if ({strb, priv_pc} !== {S_RET, e_ret_pc}) begin
          errors++;
          $display("FAIL rand%0d_ret: got strb=%b pc=%h want %b %h", it, strb, priv_pc, S_RET, e_ret_pc);
        end
        drive_random(1'b1);
        step();
      end
      checks++;
      if (strb !== S_IDLE) begin
        errors++; $display("FAIL rand%0d_idle: got strb=%b want %b", it, strb, S_IDLE);
      end
    end
    clear_events();
  endtask

  initial begin
    nRST = 1'b0;
    clear_events();
    mtvec  = 32'h0;
    mepc_r = 32'h0;
    @(negedge CLK);
    test_reset();
    test_reset_mid_sequence();
    test_illegal_fault_l();
    test_mal_s();
    test_interrupt();
    test_int_masked();
    test_ret();
    test_ret_env_m();
    test_rmgmt();
    test_pipe_clear_hold();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
